// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch slice.
// Purely declarative: no logic, no latency, no flow control.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'h3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of redirect, imem req/gnt/rvalid and decode valid/ready signals around the fetch unit.
// master = fetch sequencer side; slave = execute, instruction memory and decode side.
interface fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;
    logic            misalign_err;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr, if_pc, if_pc_plus4, misalign_err
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr, if_pc, if_pc_plus4, misalign_err
    );
endinterface

// File: rtl/fetch_pc_next.sv
// Next fetch PC select (redirect > +4 > hold) and misaligned-target detection.
// Combinational, zero latency; a misaligned redirect leaves the PC unchanged.
module fetch_pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign
);
    import fetch_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic target_misaligned;

    assign target_misaligned = |(redirect_pc[1:0] & INSTR_ALIGN_MASK[1:0]);
    assign misalign          = redirect_valid && target_misaligned;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            if (!target_misaligned) begin
                pc_next = redirect_pc;
            end
        end else if (advance) begin
            pc_next = pc + PC_STEP;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: one outstanding imem request, redirect/squash, halt on misaligned target.
// if_valid 2 cycles after REQ entry with zero-wait memory; HOLD stalls fetch until if_ready.
module fetch_sequencer #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    import fetch_pkg::*;

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_REQ  = REQ;
    localparam logic [2:0] ST_WAIT = WAIT;
    localparam logic [2:0] ST_HOLD = HOLD;
    localparam logic [2:0] ST_HALT = HALT;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [2:0]      state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, if_pc_q;
    logic            misalign_q;
    logic            misalign;
    logic            redir;
    logic            advance;
    logic            capture;

    // HALT is terminal, so redirects arriving there must not touch the PC.
    assign redir   = bus.redirect_valid && (state_q != ST_HALT);
    assign advance = (state_q == ST_HOLD) && bus.if_ready;

    fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc             (pc_q),
        .advance        (advance),
        .redirect_valid (redir),
        .redirect_pc    (bus.redirect_pc),
        .pc_next        (pc_d),
        .misalign       (misalign)
    );

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        capture = 1'b0;
        if (redir) begin
            if (misalign) begin
                state_d = ST_HALT;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_REQ;
                    ST_REQ: begin
                        if (bus.imem_gnt) begin
                            state_d = ST_WAIT;
                            kill_d  = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.imem_rvalid) begin
                            state_d = ST_REQ;
                            kill_d  = 1'b0;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end
                    ST_HOLD: state_d = ST_REQ;
                    default: state_d = state_q;
                endcase
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (bus.imem_gnt) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        state_d = kill_q ? ST_REQ : ST_HOLD;
                        kill_d  = 1'b0;
                        capture = !kill_q;
                    end
                end
                ST_HOLD: begin
                    if (bus.if_ready) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= '0;
            if_pc_q    <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            if (capture) begin
                instr_q <= bus.imem_rdata;
                if_pc_q <= pc_q;
            end
            if (misalign) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign bus.imem_req     = (state_q == ST_REQ);
    assign bus.imem_addr    = pc_q;
    assign bus.if_valid     = (state_q == ST_HOLD);
    assign bus.if_instr     = instr_q;
    assign bus.if_pc        = if_pc_q;
    assign bus.if_pc_plus4  = if_pc_q + PC_STEP;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, stall, redirects, wrap, halt, reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   mem_auto;

    fetch_sequencer_if bus();

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'hC) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    // Zero-wait memory: gnt mirrors req, rvalid one cycle after a grant.
    task automatic tick();
        logic        granted;
        logic [31:0] gaddr;
        granted = bus.imem_req && bus.imem_gnt;
        gaddr   = bus.imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            bus.imem_rvalid = granted;
            bus.imem_rdata  = granted ? mem_data(gaddr) : 32'h0;
            bus.imem_gnt    = bus.imem_req;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_auto = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.if_ready       = 1'b0;
        tick();
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.if_valid); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", bus.if_instr); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", bus.if_pc); end
        checks++; if (bus.if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc4 got=%h exp=4", bus.if_pc_plus4); end
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", bus.misalign_err); end
    endtask

    task automatic test_sequential();
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL seq_idle_req got=%b exp=0", bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_first_req got=%b exp=1", bus.imem_req); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", k, bus.imem_addr, 32'(4 * k)); end
            tick();
            checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_valid%0d got=%b exp=0", k, bus.if_valid); end
            tick();
            checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got=%b exp=1", k, bus.if_valid); end
            checks++; if (bus.if_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", k, bus.if_pc, 32'(4 * k)); end
            checks++; if (bus.if_pc_plus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL seq_pc4_%0d got=%h exp=%h", k, bus.if_pc_plus4, 32'(4 * k + 4)); end
            checks++; if (bus.if_instr !== mem_data(32'(4 * k))) begin errors++; $display("FAIL seq_instr%0d got=%h exp=%h", k, bus.if_instr, mem_data(32'(4 * k))); end
            tick();
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req%0d got=%b exp=1", k, bus.imem_req); end
        end
    endtask

    task automatic test_backpressure();
        bus.if_ready = 1'b0;
        checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL bp_addr got=%h exp=c", bus.imem_addr); end
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%b exp=1", i, bus.if_valid); end
            checks++; if (bus.if_instr !== 32'h0050_0093) begin errors++; $display("FAIL bp_instr%0d got=%h exp=00500093", i, bus.if_instr); end
            checks++; if (bus.if_pc !== 32'hC) begin errors++; $display("FAIL bp_pc%0d got=%h exp=c", i, bus.if_pc); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req%0d got=%b exp=0", i, bus.imem_req); end
            tick();
        end
        bus.if_ready = 1'b1;
        checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL bp_ready_valid got=%b exp=1", bus.if_valid); end
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL bp_next_req got=%b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL bp_next_addr got=%h exp=10", bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        mem_auto = 1'b0;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_req got=%b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rw_addr got=%h exp=100", bus.imem_addr); end
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got=%b exp=0", bus.if_valid); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rw_refetch_req got=%b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rw_refetch_addr got=%h exp=100", bus.imem_addr); end
        mem_auto = 1'b1;
        bus.imem_gnt = 1'b1;
        tick();
        tick();
        checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rw_valid got=%b exp=1", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL rw_pc got=%h exp=100", bus.if_pc); end
        checks++; if (bus.if_instr !== 32'h0001_0013) begin errors++; $display("FAIL rw_instr got=%h exp=00010013", bus.if_instr); end
    endtask

    task automatic test_redirect_hold();
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rh_squash got=%b exp=0", bus.if_valid); end
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rh_addr got=%h exp=200", bus.imem_addr); end
        tick();
        tick();
        checks++; if (bus.if_pc !== 32'h200) begin errors++; $display("FAIL rh_pc got=%h exp=200", bus.if_pc); end
        checks++; if (bus.if_instr !== 32'h0002_0013) begin errors++; $display("FAIL rh_instr got=%h exp=00020013", bus.if_instr); end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got=%h exp=fffffffc", bus.imem_addr); end
        tick();
        tick();
        checks++; if (bus.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got=%h exp=fffffffc", bus.if_pc); end
        checks++; if (bus.if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wr_pc4 got=%h exp=0", bus.if_pc_plus4); end
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wr_next_req got=%b exp=1", bus.imem_req); end
    endtask

    task automatic test_misalign();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.redirect_valid = (i < 2);
            bus.redirect_pc    = (i == 0) ? 32'h300 : 32'h301;
            checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL ma_err%0d got=%b exp=1", i, bus.misalign_err); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ma_req%0d got=%b exp=0", i, bus.imem_req); end
            checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ma_addr%0d got=%h exp=0", i, bus.imem_addr); end
            checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL ma_valid%0d got=%b exp=0", i, bus.if_valid); end
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL ma_rst_clear got=%b exp=0", bus.misalign_err); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL ma_restart_req got=%b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ma_restart_addr got=%h exp=0", bus.imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        mem_auto = 1'b0;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmw_req got=%b exp=0", bus.imem_req); end
        tick();
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rmw_stale got=%b exp=0", bus.if_valid); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rmw_req2 got=%b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_addr got=%h exp=0", bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_1111;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rmw_valid got=%b exp=1", bus.if_valid); end
        checks++; if (bus.if_instr !== 32'h1111_1111) begin errors++; $display("FAIL rmw_instr got=%h exp=11111111", bus.if_instr); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rmw_pc got=%h exp=0", bus.if_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
